// File: rtl/stack_ctrl.sv
// Push/pop controller for a small stack RAM: conditions raw buttons into release
// events, tracks occupancy, and issues single-cycle RAM write/read strobes.
module stack_ctrl #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    output logic [ADDR_W-1:0] addr,
    output logic              we,
    output logic              re,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              underflow
);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ADDR_W:0]     count_dec;
    logic                we_q, we_d;
    logic                re_q, re_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;

    logic push_s1_q, push_s2_q, push_prev_q;
    logic pop_s1_q, pop_s2_q, pop_prev_q;
    logic push_evt, pop_evt;

    // Synchronizers and release detectors; all reset low so a button held
    // across reset never looks like a release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            push_s1_q   <= 1'b0;
            push_s2_q   <= 1'b0;
            push_prev_q <= 1'b0;
            pop_s1_q    <= 1'b0;
            pop_s2_q    <= 1'b0;
            pop_prev_q  <= 1'b0;
        end else begin
            push_s1_q   <= push;
            push_s2_q   <= push_s1_q;
            push_prev_q <= push_s2_q;
            pop_s1_q    <= pop;
            pop_s2_q    <= pop_s1_q;
            pop_prev_q  <= pop_s2_q;
        end
    end

    assign push_evt = push_prev_q & ~push_s2_q;
    assign pop_evt  = pop_prev_q  & ~pop_s2_q;

    assign full      = (count_q == (ADDR_W+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign count_dec = count_q - (ADDR_W+1)'(1);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        we_d    = 1'b0;
        re_d    = 1'b0;
        if (clear) begin
            state_d = IDLE;
            count_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (push_evt && pop_evt) begin
                        state_d = IDLE;
                    end else if (push_evt) begin
                        if (full) begin
                            ovf_d = 1'b1;
                        end else begin
                            addr_d  = count_q[ADDR_W-1:0];
                            count_d = count_q + (ADDR_W+1)'(1);
                            we_d    = 1'b1;
                            state_d = WRITE;
                        end
                    end else if (pop_evt) begin
                        if (empty) begin
                            unf_d = 1'b1;
                        end else begin
                            addr_d  = count_dec[ADDR_W-1:0];
                            count_d = count_dec;
                            re_d    = 1'b1;
                            state_d = READ;
                        end
                    end
                end
                // Strobe states last one cycle; events arriving here are dropped.
                WRITE:   state_d = IDLE;
                READ:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            we_q    <= we_d;
            re_q    <= re_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign addr      = addr_q;
    assign we        = we_q;
    assign re        = re_q;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with hand-computed expectations.
module tb_stack_ctrl;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk;
    logic              reset;
    logic              push;
    logic              pop;
    logic              clear;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic              re;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              underflow;

    int n_checks = 0;
    int n_errors = 0;

    stack_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .clear     (clear),
        .addr      (addr),
        .we        (we),
        .re        (re),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Hold the selected buttons for a few cycles, release just after a rising edge.
    task automatic press(input logic do_push, input logic do_pop);
        @(posedge clk); #1;
        push = do_push;
        pop  = do_pop;
        repeat (4) @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic do_push(input int exp_addr, input int exp_count);
        press(1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1 chk("we_early", we, 0);
        @(posedge clk); #1;
        chk("we_pulse", we, 1);
        chk("we_addr", addr, exp_addr);
        chk("push_count", count, exp_count);
        @(posedge clk); #1;
        chk("we_one_cycle", we, 0);
    endtask

    task automatic do_pop(input int exp_addr, input int exp_count);
        press(1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1 chk("re_early", re, 0);
        @(posedge clk); #1;
        chk("re_pulse", re, 1);
        chk("re_addr", addr, exp_addr);
        chk("pop_count", count, exp_count);
        @(posedge clk); #1;
        chk("re_one_cycle", re, 0);
    endtask

    // Watch n cycles and report whether any strobe fired.
    task automatic watch_strobes(input int n, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (we || re) seen = 1'b1;
        end
    endtask

    logic seen;

    initial begin
        reset = 1'b1;
        push  = 1'b0;
        pop   = 1'b0;
        clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // 1) reset values
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_we", we, 0);
        chk("rst_re", re, 0);
        chk("rst_addr", addr, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // 2) fill the stack
        do_push(0, 1);
        do_push(1, 2);
        do_push(2, 3);
        chk("not_full_3", full, 0);
        do_push(3, 4);
        chk("full_4", full, 1);
        chk("empty_4", empty, 0);

        // 3) overflow, then drain
        press(1'b1, 1'b0);
        watch_strobes(6, seen);
        chk("ovf_no_we", seen, 0);
        chk("ovf_set", overflow, 1);
        chk("ovf_count", count, 4);
        do_pop(3, 3);
        do_pop(2, 2);
        do_pop(1, 1);
        do_pop(0, 0);
        chk("drain_empty", empty, 1);
        chk("ovf_sticky", overflow, 1);

        // 4) underflow, then clear
        press(1'b0, 1'b1);
        watch_strobes(6, seen);
        chk("unf_no_re", seen, 0);
        chk("unf_set", underflow, 1);
        chk("unf_count", count, 0);
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("clr_ovf", overflow, 0);
        chk("clr_unf", underflow, 0);
        chk("clr_count", count, 0);

        // 5) simultaneous release at count 2
        do_push(0, 1);
        do_push(1, 2);
        press(1'b1, 1'b1);
        watch_strobes(6, seen);
        chk("both_no_strobe", seen, 0);
        chk("both_count", count, 2);
        chk("both_ovf", overflow, 0);
        chk("both_unf", underflow, 0);

        // Button held through reset release, then released during a later reset
        push  = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        watch_strobes(5, seen);
        chk("held_no_event", seen, 0);
        chk("held_count", count, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 push = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        watch_strobes(5, seen);
        chk("rel_in_rst_no_event", seen, 0);
        chk("rel_in_rst_count", count, 0);

        // 6) reset during WRITE drops we without a clock edge
        do_push(0, 1);
        press(1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1 chk("mid_we", we, 1);
        chk("mid_addr", addr, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_we", we, 0);
        chk("async_count", count, 0);
        chk("async_addr", addr, 0);
        chk("async_empty", empty, 1);
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        do_push(0, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
